// File: rtl/dtree_walker.sv
// dtree_walker: decision-tree walk sequencer with idle-time host write arbitration
module dtree_walker #(
  parameter int WORDS = 8,
  parameter int N_FEAT = 8,
  parameter int FEAT_W = 12,
  parameter int MAX_STEPS = WORDS,
  parameter int AW = $clog2(WORDS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_FEAT*FEAT_W-1:0] features,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               label,
  output logic                     err,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_a,
  input  logic [23:0]              cfg_d,
  output logic                     cfg_ready,
  output logic                     mem_ce,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_a,
  output logic [23:0]              mem_d,
  input  logic [23:0]              mem_q
);
  localparam int SW = $clog2(MAX_STEPS + 1);
  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;
  state_t state_q, state_d;
  logic [N_FEAT*FEAT_W-1:0] feat_q, feat_d;
  logic [AW-1:0] node_q, node_d;
  logic [SW-1:0] steps_q, steps_d;
  logic [7:0] label_q, label_d;
  logic err_q, err_d;
  logic [FEAT_W-1:0] fsel;
  logic [3:0] child;
  logic go_left, bad;
  logic fetch;
  // branch decision for the node word currently on mem_q
  always_comb begin
    fsel = feat_q[mem_q[22:20]*FEAT_W +: FEAT_W];
    go_left = $signed(fsel) < $signed(mem_q[19:8]);
    child = go_left ? mem_q[7:4] : mem_q[3:0];
    bad = 32'(child) >= WORDS || 32'(steps_q) == MAX_STEPS;
  end
  // walk sequencing: latch, fetch, evaluate, report
  always_comb begin
    state_d = state_q;
    feat_d = feat_q;
    node_d = node_q;
    steps_d = steps_q;
    label_d = label_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        feat_d = features;
        node_d = '0;
        steps_d = '0;
      end
      FETCH: begin
        steps_d = steps_q + SW'(1);
        state_d = EVAL;
      end
      EVAL: begin
        state_d = mem_q[23] || bad ? DONE : FETCH;
        label_d = mem_q[23] ? mem_q[7:0] : bad ? 8'd0 : label_q;
        err_d = mem_q[23] ? 1'b0 : bad ? 1'b1 : err_q;
        node_d = mem_q[23] || bad ? node_q : child[AW-1:0];
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      feat_q <= '0;
      node_q <= '0;
      steps_q <= '0;
      label_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      feat_q <= feat_d;
      node_q <= node_d;
      steps_q <= steps_d;
      label_q <= label_d;
      err_q <= err_d;
    end
  end
  // single memory port shared between walk fetches and idle-time host writes
  always_comb begin
    busy = state_q != IDLE;
    done = !reset && state_q == DONE;
    label = label_q;
    err = err_q;
    cfg_ready = !reset && state_q == IDLE && !start;
    fetch = !reset && state_q == FETCH;
    mem_we = cfg_we && cfg_ready;
    mem_ce = fetch || mem_we;
    mem_a = fetch ? node_q : mem_we ? cfg_a : '0;
    mem_d = mem_we ? cfg_d : '0;
  end
endmodule

// File: tb/tb_dtree_walker.sv
// tb_dtree_walker: table-driven and scoreboard checks of dtree_walker with a modelled node memory
module tb_dtree_walker;
  logic clk = 0, reset = 1, start = 0, cfg_we = 0;
  logic [95:0] features = '0;
  logic [2:0] cfg_a = '0;
  logic [23:0] cfg_d = '0;
  logic busy, done, err, cfg_ready, mem_ce, mem_we;
  logic [7:0] label;
  logic [2:0] mem_a;
  logic [23:0] mem_d, mem_q;
  logic [23:0] mem [8];
  int cyc = 0, total = 0, bad = 0;
  typedef struct {logic [7:0] lab; logic e; int at;} exp_t;
  typedef struct {logic [2:0] sel; logic signed [11:0] thr; logic signed [11:0] f; logic [7:0] lab;} vec_t;
  exp_t sb[$];
  exp_t cur;
  vec_t tab[8];
  dtree_walker dut (
    .clk(clk), .reset(reset), .start(start), .features(features),
    .busy(busy), .done(done), .label(label), .err(err),
    .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_d(cfg_d), .cfg_ready(cfg_ready),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (reset) mem_q <= '0;
    else if (mem_ce) begin
      if (mem_we) mem[mem_a] <= mem_d;
      else mem_q <= mem[mem_a];
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got done=1 expected none (cyc %0d)", cyc);
      end else begin
        cur = sb.pop_front();
        check("label", {24'd0, label}, {24'd0, cur.lab});
        check("err", {31'd0, err}, {31'd0, cur.e});
        check("done_cycle", cyc, cur.at);
      end
    end
  end
  function automatic logic [95:0] mk_feat(input logic [2:0] sel, input logic signed [11:0] thr, input logic signed [11:0] f);
    logic [95:0] v;
    logic signed [11:0] o;
    o = (f < thr) ? thr : thr - 12'sd1;
    for (int k = 0; k < 8; k++) v[k*12 +: 12] = (k == int'(sel)) ? f : o;
    return v;
  endfunction
  task automatic wr(input logic [2:0] a, input logic [23:0] d);
    cfg_we = 1;
    cfg_a = a;
    cfg_d = d;
    @(posedge clk); #1;
    cfg_we = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("walk_timeout", {31'd0, n < 60}, 32'd1);
    sb.delete();
  endtask
  task automatic walk(input logic [95:0] f, input logic [7:0] lab, input logic e, input int lat);
    features = f;
    start = 1;
    sb.push_back('{lab, e, cyc + lat});
    @(posedge clk); #1;
    start = 0;
    features = ~f;
    wait_idle();
  endtask
  task automatic all_zero(input string nm);
    check({nm, "_busy"}, {31'd0, busy}, 0);
    check({nm, "_done"}, {31'd0, done}, 0);
    check({nm, "_label"}, {24'd0, label}, 0);
    check({nm, "_err"}, {31'd0, err}, 0);
    check({nm, "_cfg_ready"}, {31'd0, cfg_ready}, 0);
    check({nm, "_mem_ce"}, {31'd0, mem_ce}, 0);
    check({nm, "_mem_we"}, {31'd0, mem_we}, 0);
    check({nm, "_mem_a"}, {29'd0, mem_a}, 0);
    check({nm, "_mem_d"}, {8'd0, mem_d}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int c0;
    tab[0] = '{3'd2, 12'sd100, 12'sd99, 8'h05};
    tab[1] = '{3'd2, 12'sd100, 12'sd100, 8'h07};
    tab[2] = '{3'd2, 12'sd100, -12'sd5, 8'h05};
    tab[3] = '{3'd7, -12'sd3, -12'sd4, 8'h05};
    tab[4] = '{3'd7, -12'sd3, -12'sd3, 8'h07};
    tab[5] = '{3'd0, 12'sd2047, 12'sd2046, 8'h05};
    tab[6] = '{3'd5, 12'sd0, -12'sd2048, 8'h05};
    tab[7] = '{3'd3, -12'sd100, 12'sd2047, 8'h07};
    cfg_we = 1;
    cfg_a = 3'd3;
    cfg_d = 24'hABCDEF;
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset");
    cfg_we = 0;
    reset = 0;
    @(posedge clk); #1;
    wr(3'd0, 24'h80002A);
    features = '0;
    start = 1;
    sb.push_back('{8'h2A, 1'b0, cyc + 3});
    @(posedge clk); #1;
    start = 0;
    check("leaf_busy_k1", {31'd0, busy}, 1);
    @(posedge clk); #1;
    check("leaf_busy_k2", {31'd0, busy}, 1);
    @(posedge clk); #1;
    check("leaf_busy_k3", {31'd0, busy}, 1);
    @(posedge clk); #1;
    check("leaf_busy_k4", {31'd0, busy}, 0);
    check("leaf_label_held", {24'd0, label}, 32'h2A);
    check("leaf_done_seen", sb.size(), 0);
    wr(3'd1, 24'h800005);
    wr(3'd2, 24'h800007);
    for (int i = 0; i < 8; i++) begin
      wr(3'd0, {1'b0, tab[i].sel, tab[i].thr, 4'd1, 4'd2});
      walk(mk_feat(tab[i].sel, tab[i].thr, tab[i].f), tab[i].lab, 1'b0, 5);
    end
    wr(3'd0, 24'h000000);
    walk('0, 8'h00, 1'b1, 17);
    wr(3'd0, 24'h000009);
    walk(mk_feat(3'd0, 12'sd0, 12'sd5), 8'h00, 1'b1, 3);
    wr(3'd0, 24'h000081);
    walk(mk_feat(3'd0, 12'sd0, -12'sd1), 8'h00, 1'b1, 3);
    wr(3'd0, 24'h206412);
    cfg_we = 1;
    cfg_a = 3'd1;
    cfg_d = 24'h800099;
    features = mk_feat(3'd2, 12'sd100, 12'sd99);
    start = 1;
    #1;
    check("arb_start_ready", {31'd0, cfg_ready}, 0);
    check("arb_start_we", {31'd0, mem_we}, 0);
    sb.push_back('{8'h05, 1'b0, cyc + 5});
    @(posedge clk); #1;
    start = 0;
    cfg_we = 0;
    wait_idle();
    features = mk_feat(3'd2, 12'sd100, 12'sd99);
    start = 1;
    c0 = cyc;
    sb.push_back('{8'h05, 1'b0, cyc + 5});
    @(posedge clk); #1;
    start = 0;
    cfg_we = 1;
    cfg_a = 3'd2;
    cfg_d = 24'h80000B;
    for (int n = 0; n < 20 && busy; n++) begin
      check("arb_busy_we", {31'd0, mem_we}, 0);
      check("arb_busy_ready", {31'd0, cfg_ready}, 0);
      @(posedge clk); #1;
    end
    check("arb_idle_cycle", cyc, c0 + 6);
    check("arb_idle_ready", {31'd0, cfg_ready}, 1);
    check("arb_idle_we", {31'd0, mem_we}, 1);
    check("arb_idle_ce", {31'd0, mem_ce}, 1);
    check("arb_idle_a", {29'd0, mem_a}, 2);
    check("arb_idle_d", {8'd0, mem_d}, 32'h80000B);
    @(posedge clk); #1;
    cfg_we = 0;
    walk(mk_feat(3'd2, 12'sd100, 12'sd100), 8'h0B, 1'b0, 5);
    features = mk_feat(3'd2, 12'sd100, 12'sd99);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    all_zero("midreset");
    @(posedge clk); #1;
    reset = 0;
    repeat (6) @(posedge clk);
    #1;
    check("midreset_idle", {31'd0, busy}, 0);
    walk(mk_feat(3'd2, 12'sd100, 12'sd99), 8'h05, 1'b0, 5);
    walk(mk_feat(3'd2, 12'sd100, 12'sd100), 8'h0B, 1'b0, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dtree_walker.md
# dtree_walker

Sequencer for the decision-tree coefficient memory (24-bit words, registered 1-cycle read, synchronous active-high reset clears read data). The block latches a feature vector on `start`, walks the tree from node 0 by reading one node per step, compares the selected feature with the node threshold, and reports the leaf class label. While idle it also arbitrates host configuration writes onto the same single memory port. It sits between the spike feature extractor and the classification output stage.

## Interface
- `WORDS`, 8: memory depth in nodes. Must be ≤16 and a power of 2.
- `N_FEAT`, 8: number of features. Fixed by the 3-bit select field.
- `FEAT_W`, 12: feature and threshold width. Signed two's complement.
- `MAX_STEPS`, `WORDS`: maximum node reads per classification before abort.
- `AW`, `$clog2(WORDS)`: derived memory address width.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: request a classification. Sampled only in IDLE.
- `features` in N_FEAT*FEAT_W: feature k occupies bits [k*FEAT_W +: FEAT_W].
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the result is valid.
- `label` out 8: class label. Held until the next `done`.
- `err` out 1: valid with `done`. Indicates a step-limit overrun or a child address ≥ WORDS.
- `cfg_we` in 1: host node-write request.
- `cfg_a` in AW: node address for the host write.
- `cfg_d` in 24: node data for the host write.
- `cfg_ready` out 1: host write accepted this cycle.
- `mem_ce` out 1: memory port chip enable.
- `mem_we` out 1: memory port write enable.
- `mem_a` out AW: memory port address.
- `mem_d` out 24: memory port write data.
- `mem_q` in 24: memory read data, valid the cycle after `mem_ce`.

## Operation
- Node format:
  - `[23]` leaf flag.
  - Leaf node: `[7:0]` = label.
  - Internal node: `[22:20]` feature select, `[19:8]` signed threshold, `[7:4]` left child, `[3:0]` right child.
- Branch rule: if `feature[sel] < threshold` (signed compare), go left; otherwise go right.
- FSM states and transitions:
  - **IDLE**: on `start`, latch `features` into `feat_r`, set `node` = 0 and `steps` = 0, go to FETCH.
  - **FETCH**: assert `mem_ce`=1, `mem_we`=0, `mem_a`=`node`; increment `steps`; go to EVAL.
  - **EVAL**: `mem_q` is valid this cycle.
    - Leaf node: load `label` = `mem_q[7:0]`, `err` = 0, go to DONE.
    - Internal node, child ≥ WORDS or `steps` == MAX_STEPS: load `label` = 0, `err` = 1, go to DONE.
    - Otherwise: set `node` = selected child, go to FETCH.
  - **DONE**: `done` = 1 for one cycle, then go to IDLE.
- Host arbitration:
  - `cfg_ready` = (state == IDLE) && !`start`. `start` has priority over `cfg_we`.
  - When `cfg_we` && `cfg_ready`: drive `mem_ce`=1, `mem_we`=1, `mem_a`=`cfg_a`, `mem_d`=`cfg_d` in the same cycle.
  - A `cfg_we` request seen while `cfg_ready`=0 is ignored. The host must hold the request until it is accepted.
- All memory port outputs are combinational from the state and the host request. `mem_d` = 0 when no write is in progress.
- `start` while `busy` is ignored. `features` changes after the latch do not affect the walk in progress.
- Reset values: state IDLE, `busy`=0, `done`=0, `label`=0, `err`=0, `cfg_ready`=0 during reset, and all `mem_*` = 0.
- Reset in the middle of a walk aborts it: no `done` is produced and memory contents are untouched.

## Timing
- `start` sampled at edge k:
  - FETCH is in cycle k+1 (node 0).
  - EVAL is in cycle k+2.
- Each internal node costs 2 cycles.
- Path with d internal nodes followed by a leaf: `done` is high in cycle k+3+2d.
- Back-to-back operation: `start` can be accepted in the cycle after DONE, when the block is back in IDLE.
- Worst-case latency is 1+2*MAX_STEPS cycles after the start edge. This covers an error abort.
- A host write accepted at edge j is visible to a FETCH in cycle j+1 or later.

## Test plan
- **Single leaf**: write node0 = 0x8000_2A, then pulse `start`. Expect `done` 3 cycles later, `label`=0x2A, `err`=0, and `busy` high during cycles k+1..k+3.
- **Two-level walk**: write the following nodes.
  - node0: sel=2, thr=100, L=1, R=2.
  - node1: leaf 0x05.
  - node2: leaf 0x07.
  - Expected results:
    - `feature2`=99 gives `label` 0x05 at k+5.
    - `feature2`=100 gives `label` 0x07.
    - `feature2`=−5 gives `label` 0x05.
- **Loop**: write node0 as internal with L=R=0. Expect `done` with `err`=1, `label`=0 after 8 fetches (cycle k+17).
- **Bad child**: write node0 with R=9 and a feature value that selects right. Expect `err`=1 at k+3.
- **Arbitration**:
  - `cfg_we` together with `start` in IDLE gives `cfg_ready`=0 and no write.
  - `cfg_we` held during `busy` is accepted in the first IDLE cycle, with the `mem_we` pulse observed.
- **Reset mid-walk**: assert `reset` at k+2. Expect no `done`, all outputs 0, and a following `start` that classifies correctly using the unchanged memory.
